// File: rtl/mem_port_arbiter.sv
// Two-host to one-device memory port arbiter with same-cycle grant and 1-cycle response routing.
// Supports round-robin or host-B priority with host-A anti-starvation.
module mem_port_arbiter #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32,
    parameter int FixedPrio = 0,
    parameter int MaxWait   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 a_req_i,
    output logic                 a_gnt_o,
    input  logic [AddrWidth-1:0] a_addr_i,
    input  logic                 a_we_i,
    input  logic [3:0]           a_be_i,
    input  logic [DataWidth-1:0] a_wdata_i,
    output logic                 a_rvalid_o,
    output logic [DataWidth-1:0] a_rdata_o,

    input  logic                 b_req_i,
    output logic                 b_gnt_o,
    input  logic [AddrWidth-1:0] b_addr_i,
    input  logic                 b_we_i,
    input  logic [3:0]           b_be_i,
    input  logic [DataWidth-1:0] b_wdata_i,
    output logic                 b_rvalid_o,
    output logic [DataWidth-1:0] b_rdata_o,

    output logic                 dev_req_o,
    output logic [AddrWidth-1:0] dev_addr_o,
    output logic                 dev_we_o,
    output logic [3:0]           dev_be_o,
    output logic [DataWidth-1:0] dev_wdata_o,
    input  logic [DataWidth-1:0] dev_rdata_i
);

    localparam logic [3:0] WaitLimit = 4'(MaxWait);

    logic       last_gnt_b;
    logic [3:0] wait_cnt;
    logic       rsp_valid;
    logic       rsp_owner_b;
    logic       a_wins;

    // a_wins only matters on contention; a lone requester is always granted.
    always_comb begin
        if (FixedPrio != 0) begin
            a_wins = (wait_cnt == WaitLimit);
        end else begin
            a_wins = last_gnt_b;
        end
    end

    assign a_gnt_o = a_req_i & (~b_req_i | a_wins);
    assign b_gnt_o = b_req_i & ~a_gnt_o;

    assign dev_req_o   = a_req_i | b_req_i;
    assign dev_addr_o  = b_gnt_o ? b_addr_i  : a_addr_i;
    assign dev_we_o    = b_gnt_o ? b_we_i    : a_we_i;
    assign dev_be_o    = b_gnt_o ? b_be_i    : a_be_i;
    assign dev_wdata_o = b_gnt_o ? b_wdata_i : a_wdata_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_gnt_b  <= 1'b1;
            wait_cnt    <= 4'd0;
            rsp_valid   <= 1'b0;
            rsp_owner_b <= 1'b0;
        end else begin
            if (a_gnt_o) begin
                last_gnt_b <= 1'b0;
            end else if (b_gnt_o) begin
                last_gnt_b <= 1'b1;
            end

            if (a_req_i && !a_gnt_o) begin
                if (wait_cnt < WaitLimit) begin
                    wait_cnt <= wait_cnt + 4'd1;
                end
            end else begin
                wait_cnt <= 4'd0;
            end

            rsp_valid   <= a_gnt_o | b_gnt_o;
            rsp_owner_b <= b_gnt_o;
        end
    end

    // The device answers exactly one cycle after the request, so the
    // registered owner alone steers the read data back.
    assign a_rvalid_o = rsp_valid & ~rsp_owner_b;
    assign b_rvalid_o = rsp_valid &  rsp_owner_b;
    assign a_rdata_o  = a_rvalid_o ? dev_rdata_i : '0;
    assign b_rdata_o  = b_rvalid_o ? dev_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin instance and a fixed-priority instance share stimulus;
// expected responses are queued per instance and popped by a negedge monitor.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        owner_b;
        logic [31:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 1'b0, b_req = 1'b0;
    logic [31:0] a_addr = '0, b_addr = '0, a_wdata = '0, b_wdata = '0;
    logic        a_we = 1'b0, b_we = 1'b0;
    logic [3:0]  a_be = 4'hF, b_be = 4'hF;
    logic [31:0] dev_rdata;

    logic        g0a, g0b, v0a, v0b, dreq0, dwe0;
    logic [31:0] rd0a, rd0b, daddr0, dwd0;
    logic [3:0]  dbe0;
    logic        g1a, g1b, v1a, v1b, dreq1, dwe1;
    logic [31:0] rd1a, rd1b, daddr1, dwd1;
    logic [3:0]  dbe1;
    logic        p0a, p0b, p1a, p1b;

    int   cyc = 0;
    int   beef_cyc = -1;
    int   checks = 0;
    int   errors = 0;
    rsp_t q0[$];
    rsp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign dev_rdata = (cyc == beef_cyc) ? 32'hDEAD_BEEF : {8'h5A, cyc[23:0]};

    function automatic logic [31:0] rd_val(input int n);
        return (n == beef_cyc) ? 32'hDEAD_BEEF : {8'h5A, n[23:0]};
    endfunction

    mem_port_arbiter #(.DataWidth(32), .AddrWidth(32), .FixedPrio(0), .MaxWait(4)) dut_rr (
        .clk_i(clk), .rst_ni(rst_n),
        .a_req_i(a_req), .a_gnt_o(g0a), .a_addr_i(a_addr), .a_we_i(a_we), .a_be_i(a_be),
        .a_wdata_i(a_wdata), .a_rvalid_o(v0a), .a_rdata_o(rd0a),
        .b_req_i(b_req), .b_gnt_o(g0b), .b_addr_i(b_addr), .b_we_i(b_we), .b_be_i(b_be),
        .b_wdata_i(b_wdata), .b_rvalid_o(v0b), .b_rdata_o(rd0b),
        .dev_req_o(dreq0), .dev_addr_o(daddr0), .dev_we_o(dwe0), .dev_be_o(dbe0),
        .dev_wdata_o(dwd0), .dev_rdata_i(dev_rdata)
    );

    mem_port_arbiter #(.DataWidth(32), .AddrWidth(32), .FixedPrio(1), .MaxWait(4)) dut_fp (
        .clk_i(clk), .rst_ni(rst_n),
        .a_req_i(a_req), .a_gnt_o(g1a), .a_addr_i(a_addr), .a_we_i(a_we), .a_be_i(a_be),
        .a_wdata_i(a_wdata), .a_rvalid_o(v1a), .a_rdata_o(rd1a),
        .b_req_i(b_req), .b_gnt_o(g1b), .b_addr_i(b_addr), .b_we_i(b_we), .b_be_i(b_be),
        .b_wdata_i(b_wdata), .b_rvalid_o(v1b), .b_rdata_o(rd1b),
        .dev_req_o(dreq1), .dev_addr_o(daddr1), .dev_we_o(dwe1), .dev_be_o(dbe1),
        .dev_wdata_o(dwd1), .dev_rdata_i(dev_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Grant history, cleared with reset so a dropped response is not expected.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0a <= 1'b0; p0b <= 1'b0; p1a <= 1'b0; p1b <= 1'b0;
        end else begin
            p0a <= g0a; p0b <= g0b; p1a <= g1a; p1b <= g1b;
        end
    end

    task automatic mon(input int d, input logic va, input logic vb,
                       input logic [31:0] ra, input logic [31:0] rb,
                       input logic ga, input logic gb, input logic dreq,
                       input logic pa, input logic pb);
        rsp_t e;
        checks++;
        assert (!(ga && gb)) else begin
            errors++; $display("FAIL dut%0d both_gnt a=%b b=%b", d, ga, gb);
        end
        checks++;
        assert (dreq == (a_req | b_req)) else begin
            errors++; $display("FAIL dut%0d dev_req actual=%b required=%b", d, dreq, a_req | b_req);
        end
        checks++;
        assert (va == pa && vb == pb) else begin
            errors++; $display("FAIL dut%0d rvalid_vs_gnt rvalid=%b%b prev_gnt=%b%b", d, va, vb, pa, pb);
        end
        if (!va) chk("rdata_a_idle", ra, 32'h0);
        if (!vb) chk("rdata_b_idle", rb, 32'h0);
        if (va || vb) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                checks++; errors++;
                $display("FAIL dut%0d unexpected_rsp rvalid=%b%b required=none", d, va, vb);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("dut%0d rsp_owner_b", d), {31'b0, vb}, {31'b0, e.owner_b});
                chk($sformatf("dut%0d rsp_data", d), vb ? rb : ra, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, v0a, v0b, rd0a, rd0b, g0a, g0b, dreq0, p0a, p0b);
            mon(1, v1a, v1b, rd1a, rd1b, g1a, g1b, dreq1, p1a, p1b);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state; grant and dev_req stay combinational while in reset.
        #3;
        chk("rst_a_rvalid", {31'b0, v0a}, 32'h0);
        chk("rst_b_rvalid", {31'b0, v0b}, 32'h0);
        chk("rst_a_rdata", rd0a, 32'h0);
        chk("rst_b_rdata", rd1b, 32'h0);
        a_req = 1'b1;
        #1;
        chk("rst_comb_gnt", {31'b0, g0a}, 32'h1);
        chk("rst_comb_dev_req", {31'b0, dreq1}, 32'h1);
        a_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous contention: round-robin A,B,A,B..; fixed-prio B,B,B,B,A repeating.
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            a_req = 1'b1; b_req = 1'b1;
            a_addr = 32'h1000 + 32'(i); b_addr = 32'h2000 + 32'(i);
            #1;
            chk($sformatf("rr_gnt_a_%0d", i), {31'b0, g0a}, {31'b0, (i % 2 == 0)});
            chk($sformatf("fp_gnt_a_%0d", i), {31'b0, g1a}, {31'b0, (i % 5 == 4)});
            chk($sformatf("rr_addr_%0d", i), daddr0, (i % 2 == 0) ? a_addr : b_addr);
            chk($sformatf("fp_addr_%0d", i), daddr1, (i % 5 == 4) ? a_addr : b_addr);
            q0.push_back('{owner_b: (i % 2 == 1), data: rd_val(cyc + 1)});
            q1.push_back('{owner_b: (i % 5 != 4), data: rd_val(cyc + 1)});
        end
        next_cycle();
        a_req = 1'b0; b_req = 1'b0;

        // Single-host read from A.
        next_cycle();
        a_req = 1'b1; a_addr = 32'h0010_0040; a_we = 1'b0; beef_cyc = cyc + 1;
        #1;
        chk("single_gnt_a", {31'b0, g0a}, 32'h1);
        chk("single_gnt_b", {31'b0, g0b}, 32'h0);
        chk("single_addr", daddr0, 32'h0010_0040);
        q0.push_back('{owner_b: 1'b0, data: 32'hDEAD_BEEF});
        q1.push_back('{owner_b: 1'b0, data: 32'hDEAD_BEEF});

        // B write issued while A's read response is returning.
        next_cycle();
        a_req = 1'b0;
        b_req = 1'b1; b_we = 1'b1; b_be = 4'b0011; b_wdata = 32'h1234_5678; b_addr = 32'h8000_0000;
        #1;
        chk("single_a_rvalid", {31'b0, v0a}, 32'h1);
        chk("single_a_rdata", rd0a, 32'hDEAD_BEEF);
        chk("single_b_rvalid", {31'b0, v0b}, 32'h0);
        chk("wr_gnt_b", {31'b0, g0b}, 32'h1);
        chk("wr_dev_we", {31'b0, dwe0}, 32'h1);
        chk("wr_dev_be", {28'b0, dbe1}, 32'h3);
        chk("wr_dev_wdata", dwd0, 32'h1234_5678);
        chk("wr_dev_addr", daddr1, 32'h8000_0000);
        chk("wr_fp_we", {31'b0, dwe1}, 32'h1);
        chk("wr_fp_wdata", dwd1, 32'h1234_5678);
        q0.push_back('{owner_b: 1'b1, data: rd_val(cyc + 1)});
        q1.push_back('{owner_b: 1'b1, data: rd_val(cyc + 1)});
        next_cycle();
        b_req = 1'b0; b_we = 1'b0; b_be = 4'hF;
        #1;
        chk("wr_b_rvalid", {31'b0, v0b}, 32'h1);

        // Reset while A's response is pending: rvalid drops asynchronously.
        next_cycle();
        a_req = 1'b1; a_addr = 32'h0000_0100;
        #1;
        chk("rstmid_gnt_a", {31'b0, g0a}, 32'h1);
        next_cycle();
        a_req = 1'b0;
        chk("rstmid_rvalid_before", {31'b0, v0a}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_rr_rvalid", {31'b0, v0a}, 32'h0);
        chk("rstmid_fp_rvalid", {31'b0, v1a}, 32'h0);
        chk("rstmid_rdata", rd0a, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First contention after reset: round-robin grants A, fixed-prio grants B.
        next_cycle();
        a_req = 1'b1; b_req = 1'b1;
        #1;
        chk("post_rst_rr_gnt_a", {31'b0, g0a}, 32'h1);
        chk("post_rst_fp_gnt_b", {31'b0, g1b}, 32'h1);
        q0.push_back('{owner_b: 1'b0, data: rd_val(cyc + 1)});
        q1.push_back('{owner_b: 1'b1, data: rd_val(cyc + 1)});
        next_cycle();
        a_req = 1'b0; b_req = 1'b0;

        repeat (3) next_cycle();
        chk("q0_drained", 32'(q0.size()), 32'h0);
        chk("q1_drained", 32'(q1.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DataWidth, default 32, meaning data bus width in bits.
REQ-002 SHALL have parameter AddrWidth, default 32, meaning address bus width in bits.
REQ-003 SHALL have parameter FixedPrio, default 0, meaning the arbitration mode: 0 = round-robin, 1 = host B priority with anti-starvation.
REQ-004 SHALL have parameter MaxWait, default 4 (range 1..15), meaning the maximum number of consecutive stalled cycles for host A in FixedPrio mode.
REQ-005 SHALL have port clk_i, input, 1 bit, the single clock; all state is on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1 bit, the reset: asynchronous and active-low.
REQ-007 SHALL have ports a_req_i (input, 1), a_gnt_o (output, 1), a_addr_i (input, AddrWidth), a_we_i (input, 1), a_be_i (input, 4), a_wdata_i (input, DataWidth), a_rvalid_o (output, 1) and a_rdata_o (output, DataWidth), forming host A (instruction fetch).
REQ-008 SHALL have the host B (data) port set b_req_i, b_gnt_o, b_addr_i, b_we_i, b_be_i, b_wdata_i, b_rvalid_o, b_rdata_o, with the same directions and widths as host A.
REQ-009 SHALL have the device port set: dev_req_o (output, 1), dev_addr_o (output, AddrWidth), dev_we_o (output, 1), dev_be_o (output, 4), dev_wdata_o (output, DataWidth) and dev_rdata_i (input, DataWidth).
- The device accepts every request and returns rdata exactly 1 cycle later.
- The device has no gnt or rvalid.

Function
REQ-010 Grant SHALL be combinational in the request cycle: x_gnt_o = x_req_i AND x selected; at most one gnt is high per cycle.
REQ-011 dev_req_o SHALL equal a_req_i OR b_req_i.
- dev_addr_o, dev_we_o, dev_be_o and dev_wdata_o SHALL be muxed from the granted host.
- With no request they SHALL be muxed from host A.
REQ-012 A single requester SHALL always be granted in the same cycle, in both modes.
REQ-013 Round-robin mode (FixedPrio = 0): on contention, the host not granted most recently SHALL win.
- last_gnt is a 1-bit register, updated on every grant.
REQ-014 FixedPrio mode: on contention host B SHALL win, unless wait_cnt = MaxWait, in which case host A SHALL win.
REQ-015 wait_cnt SHALL be a 4-bit register updated each cycle as follows:
- increment, saturating at MaxWait, when a_req_i = 1 and a_gnt_o = 0;
- clear to 0 when a_gnt_o = 1 or a_req_i = 0.
- wait_cnt is maintained in both modes but only affects arbitration in FixedPrio mode.
REQ-016 A response register rsp_valid/rsp_owner SHALL capture, on every grant, valid = 1 and owner = the granted host; otherwise it captures valid = 0.
REQ-017 x_rvalid_o SHALL equal rsp_valid AND (rsp_owner == x), so response latency is exactly 1 cycle after gnt.
- Writes also receive an rvalid.
REQ-018 x_rdata_o SHALL equal dev_rdata_i when x_rvalid_o = 1, and 0 otherwise.
REQ-019 Back-to-back grants SHALL be allowed every cycle, including alternating owners; the response for cycle N and the grant for cycle N+1 coexist without conflict.
REQ-020 Host signals other than req are don't-care while req is low; they must be held stable by the host while req is high and gnt is low.

Reset
REQ-021 While rst_ni = 0, the following SHALL hold:
- last_gnt = B, so host A wins the first round-robin contention;
- wait_cnt = 0, rsp_valid = 0, rsp_owner = A;
- a_rvalid_o = b_rvalid_o = 0 and both rdata outputs = 0.
REQ-022 gnt and dev_* outputs SHALL remain combinational during reset; an integrator gates requests externally if required.
REQ-023 Reset asserted with a response pending SHALL drop rvalid immediately (asynchronously); no response is delivered after reset release.

Verification
REQ-024 The bench SHALL cover single-host operation.
- Stimulus: A read at 0x0010_0040 alone, dev_rdata_i = 0xDEAD_BEEF in the next cycle.
- Required response: a_gnt_o = 1 in the same cycle; a_rvalid_o = 1 one cycle later with a_rdata_o = 0xDEAD_BEEF; b_rvalid_o = 0.
REQ-025 The bench SHALL cover round-robin contention.
- Stimulus: FixedPrio = 0; A and B request continuously for 4 cycles from reset.
- Required response: grant order A, B, A, B; rvalid owners lag by 1 cycle in the same order.
REQ-026 The bench SHALL cover anti-starvation.
- Stimulus: FixedPrio = 1, MaxWait = 4; A and B request continuously.
- Required response: grant order B, B, B, B, A, then the pattern repeats (wait_cnt 0,1,2,3,4 then cleared).
REQ-027 The bench SHALL cover a write with response.
- Stimulus: B writes be = 4'b0011, wdata = 0x1234_5678 to 0x8000_0000.
- Required response: dev_we_o = 1, dev_be_o = 4'b0011 and dev_wdata_o = 0x1234_5678 in the grant cycle; b_rvalid_o = 1 in the next cycle.
REQ-028 The bench SHALL cover reset mid-response.
- Stimulus: assert rst_ni = 0 in the cycle after an A grant.
- Required response: a_rvalid_o falls to 0 without waiting for a clock edge; after release, the first contention grants A.
REQ-029 The bench SHALL check throughout, by assertion:
- never both gnt high;
- rvalid count equals gnt count per host;
- dev_req_o == a_req_i | b_req_i.
